hazard_ctrl_unit: RTL
=====================

# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage MIPS core, sitting beside the IF/ID, ID/EX and EX/MEM pipeline registers and the PC. It detects load-use hazards and inserts a configurable number of bubbles via a registered stall FSM. It squashes younger instructions when a branch resolved in MEM is taken, and freezes the whole pipeline while data memory is busy. Saturating performance counters report stall and flush activity.

## Interface
- REG_ADDR_W, 5, register-address width
- LOAD_USE_STALLS, 1, bubble cycles per load-use hazard; legal range 1..7
- CNT_W, 16, width of performance counters
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; asynchronous, active-high
- pcsrc_select_i  in  1  branch in MEM resolved taken
- dmem_busy_i  in  1  data memory not ready; freeze pipeline
- memread_ex_i  in  1  instruction in EX is a load
- rt_addr_idex_i  in  REG_ADDR_W  load destination (ID/EX rt)
- rs_addr_ifid_i  in  REG_ADDR_W  ID-stage source rs
- rt_addr_ifid_i  in  REG_ADDR_W  ID-stage source rt
- uses_rt_ifid_i  in  1  ID instruction reads rt (0 for I-type ALU/load)
- clear_cnt_i  in  1  synchronous counter clear
- pc_write_o  out  1  PC load enable
- ifid_write_o  out  1  IF/ID load enable
- ifid_flush_o  out  1  IF/ID clear to NOP
- ctrl_reset_id_o  out  1  zero controls entering ID/EX
- ctrl_reset_ex_o  out  1  zero controls entering EX/MEM
- ctrl_reset_mem_o  out  1  zero controls entering MEM/WB
- pipe_hold_o  out  1  hold ID/EX, EX/MEM, MEM/WB
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0 (excluding reset)
- flush_cnt_o  out  CNT_W  taken-branch flushes

## Operation
- Hazard hit: memread_ex_i & rt_addr_idex_i!=0 & (rs_addr_ifid_i==rt_addr_idex_i | (uses_rt_ifid_i & rt_addr_ifid_i==rt_addr_idex_i)).
- FSM states: RUN, LU_STALL; 3-bit remaining-count register rem.
- Priority per cycle: dmem_busy_i > pcsrc_select_i > load-use.
- Busy: pc_write=0, ifid_write=0, pipe_hold=1, all resets 0; state, rem, flush_cnt frozen; stall_cnt increments.
- Branch taken (not busy): pc_write=1, ifid_write=1, ifid_flush=1, ctrl_reset_id=1, ctrl_reset_ex=1, ctrl_reset_mem=0; next state RUN, rem=0 (aborts any stall); flush_cnt+1.
- RUN, hit: pc_write=0, ifid_write=0, ctrl_reset_id=1; if LOAD_USE_STALLS>1, next LU_STALL with rem=LOAD_USE_STALLS-1, else stay RUN.
- LU_STALL: same outputs as hit; rem-1 each cycle; rem==1 -> next RUN. Hit condition ignored in LU_STALL.
- Otherwise: pc_write=1, ifid_write=1, all others 0.
- Counters saturate at all-ones; clear_cnt_i zeroes both next edge, overriding same-cycle increment.

## Timing
- Outputs combinational from state and inputs, same cycle; state, rem, counters registered.
- Total stall cycles per hazard exactly LOAD_USE_STALLS; back-to-back hazard after return to RUN re-detected normally.
- Reset (asynchronous, while rst_i=1): state RUN, rem 0, counters 0; outputs pc_write=0, ifid_write=0, ifid_flush=1, ctrl_reset_id/ex/mem=1, pipe_hold=0. First normal cycle follows the first edge after deassertion.
- Reset mid-stall: stall abandoned immediately, no residual bubbles.

## Structure
- Package hazard_pkg: state enum (RUN, LU_STALL), MAX_LOAD_USE_STALLS=7, output-bundle constants for RUN/stall/flush/reset.
- Sub-module sat_counter (CNT_W, inc, clr), instantiated twice.

## Test plan
- LOAD_USE_STALLS=1: memread_ex=1, rt_idex=8, rs_ifid=8 -> one cycle pc_write=0, ctrl_reset_id=1; next cycle RUN; stall_cnt=1.
- LOAD_USE_STALLS=3, rt_idex=9=rt_ifid, uses_rt=1 -> three consecutive stall cycles, then pc_write=1; uses_rt=0 -> no stall; rt_idex=0 -> no stall.
- Stall in LU_STALL (rem=2) plus pcsrc_select=1 -> that cycle ifid_flush=1, ctrl_reset_id/ex=1, pc_write=1; next RUN; flush_cnt=1.
- dmem_busy=1 for 4 cycles during LU_STALL -> pipe_hold=1, rem frozen, stall_cnt+4; stall resumes with same remaining count.
- CNT_W=4: 20 stall cycles -> stall_cnt=15 held; clear_cnt=1 with stall -> 0.
- rst_i pulsed asynchronously mid-LU_STALL -> outputs take reset values before next edge; state RUN after release.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// stall FSM states and the fixed control-output bundles driven in each mode.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hz_state_e;

  localparam int unsigned MAX_LOAD_USE_STALLS = 7;
  localparam int unsigned REM_W               = 3;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic ctrl_reset_id;
    logic ctrl_reset_ex;
    logic ctrl_reset_mem;
    logic pipe_hold;
  } hz_ctrl_t;

  // Field order: pc_write, ifid_write, ifid_flush, reset_id, reset_ex, reset_mem, pipe_hold
  localparam hz_ctrl_t CTRL_RUN   = 7'b1100000;
  localparam hz_ctrl_t CTRL_STALL = 7'b0001000;
  localparam hz_ctrl_t CTRL_FLUSH = 7'b1111100;
  localparam hz_ctrl_t CTRL_BUSY  = 7'b0000001;
  localparam hz_ctrl_t CTRL_RESET = 7'b0011110;

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch squash, dmem freeze,
// plus saturating stall/flush counters.
//   state    | meaning
//   RUN      | normal flow; load-use hazards detected here
//   LU_STALL | inserting further bubbles; rem_q bubbles still owed
module hazard_ctrl_unit #(
  parameter int unsigned REG_ADDR_W      = 5,
  parameter int unsigned LOAD_USE_STALLS = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pcsrc_select_i,
  input  logic                  dmem_busy_i,
  input  logic                  memread_ex_i,
  input  logic [REG_ADDR_W-1:0] rt_addr_idex_i,
  input  logic [REG_ADDR_W-1:0] rs_addr_ifid_i,
  input  logic [REG_ADDR_W-1:0] rt_addr_ifid_i,
  input  logic                  uses_rt_ifid_i,
  input  logic                  clear_cnt_i,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ifid_flush_o,
  output logic                  ctrl_reset_id_o,
  output logic                  ctrl_reset_ex_o,
  output logic                  ctrl_reset_mem_o,
  output logic                  pipe_hold_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  import hazard_pkg::*;

  localparam logic [REM_W-1:0] REM_ONE     = REM_W'(1);
  localparam logic [REM_W-1:0] REM_INIT    = REM_W'(LOAD_USE_STALLS - 1);
  localparam bit               MULTI_STALL = (LOAD_USE_STALLS > 1);

  hz_state_e        state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  hz_ctrl_t         ctrl;
  logic             lu_hit;
  logic             flush_inc;

  // $zero is never a real producer, so a load into r0 cannot create a hazard.
  assign lu_hit = memread_ex_i && (rt_addr_idex_i != '0) &&
                  ((rs_addr_ifid_i == rt_addr_idex_i) ||
                   (uses_rt_ifid_i && (rt_addr_ifid_i == rt_addr_idex_i)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ctrl    = CTRL_RUN;
    if (rst_i) begin
      ctrl = CTRL_RESET;
    end else if (dmem_busy_i) begin
      ctrl = CTRL_BUSY;
    end else if (pcsrc_select_i) begin
      ctrl    = CTRL_FLUSH;
      state_d = RUN;
      rem_d   = '0;
    end else if (state_q == LU_STALL) begin
      ctrl = CTRL_STALL;
      if (rem_q <= REM_ONE) begin
        state_d = RUN;
        rem_d   = '0;
      end else begin
        rem_d = rem_q - REM_ONE;
      end
    end else if (lu_hit) begin
      ctrl = CTRL_STALL;
      if (MULTI_STALL) begin
        state_d = LU_STALL;
        rem_d   = REM_INIT;
      end
    end
  end

  assign pc_write_o       = ctrl.pc_write;
  assign ifid_write_o     = ctrl.ifid_write;
  assign ifid_flush_o     = ctrl.ifid_flush;
  assign ctrl_reset_id_o  = ctrl.ctrl_reset_id;
  assign ctrl_reset_ex_o  = ctrl.ctrl_reset_ex;
  assign ctrl_reset_mem_o = ctrl.ctrl_reset_mem;
  assign pipe_hold_o      = ctrl.pipe_hold;

  assign flush_inc = pcsrc_select_i && !dmem_busy_i && !rst_i;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (!ctrl.pc_write),
    .clr_i (clear_cnt_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_inc),
    .clr_i (clear_cnt_i),
    .cnt_o (flush_cnt_o)
  );

endmodule
